// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the instruction fetch stage
// (fetch_unit, fetch_fifo, fetch_unit_if).
package fetch_unit_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) shown to decode when nothing is buffered.
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

    // Default first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered instruction: the word and the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Sequential fetch step; wraps 0xFFFF_FFFC -> 0x0000_0000 naturally.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory request/response channel, the
// redirect input from execute and the instruction channel towards decode.
//
// Handshake rule for every valid/ready pair here: a transfer happens in a cycle
// where valid and ready are both 1 at the rising edge; valid never depends on
// ready of the same channel, and the payload is only meaningful while valid=1.
// imem_resp_valid has no ready: memory returns words in request order and the
// fetch stage always accepts them.
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        fetch_trap;

    // Fetch stage side.
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output ins_valid,
        input  ins_ready,
        output ins,
        output ins_pc,
        output fetch_trap
    );

    // Environment side: memory, execute and decode.
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  ins_valid,
        output ins_ready,
        input  ins,
        input  ins_pc,
        input  fetch_trap
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry buffer of {pc, word} pairs between the memory
// response channel and decode. Synchronous clear wins over push and pop.
// The caller guarantees push never targets a full buffer and pop never an
// empty one.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents of free slots are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Keeps the PC, issues in-order word
// requests to instruction memory, buffers responses with their PCs and hands
// them to decode. A redirect from execute flushes the buffer and discards
// responses still in flight.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to raise fetch_trap on a redirect
// to a non word-aligned target (fetch stalls until an aligned redirect). Without
// it fetch_trap is tied low and redirect targets are forced word-aligned.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          fifo_empty;
    logic          trap_q;
    logic [31:0]   redirect_tgt;

    logic          redirect;
    logic          resp_in;
    logic          req_valid;
    logic          req_fire;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic          redirect_misaligned;

    assign redirect_tgt        = bus.redirect_pc;
    assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);

    // Trap flag: set by a misaligned redirect, cleared by the next aligned one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (redirect) begin
            trap_q <= redirect_misaligned;
        end
    end
`else
    logic          unused_redirect_lsbs;

    assign redirect_tgt         = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign trap_q               = 1'b0;
`endif

    assign redirect = bus.redirect_valid;
    assign resp_in  = bus.imem_resp_valid;

    // A pop is ignored in a redirect cycle because the whole buffer is cleared.
    assign pop = !fifo_empty && bus.ins_ready && !redirect;

    // Slots already claimed by in-flight requests plus buffered words. A slot
    // being popped this cycle counts as free, which keeps a 1-cycle memory
    // streaming one instruction per cycle with only DEPTH=2 slots.
    assign occupancy = {1'b0, outstanding_q} + {1'b0, fifo_count} - (CW+1)'(pop);

    assign req_valid = rst_n && !redirect && !trap_q && (occupancy < (CW+1)'(DEPTH));
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Responses while stale requests drain, or in a redirect cycle, are discarded.
    assign push = resp_in && !redirect && (drop_q == '0);

    assign push_entry.pc   = resp_pc_q;
    assign push_entry.word = bus.imem_resp_data;

    // PC, in-flight count, drop count and the PC owed to the next kept response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(resp_in);
            if (redirect) begin
                pc_q      <= redirect_tgt;
                resp_pc_q <= redirect_tgt;
                // Everything still in flight after this cycle's response is stale.
                drop_q    <= outstanding_q - CW'(resp_in);
            end else begin
                if (req_fire) begin
                    pc_q <= pc_next(pc_q);
                end
                if (resp_in) begin
                    if (drop_q != '0) begin
                        drop_q <= drop_q - CW'(1);
                    end else begin
                        resp_pc_q <= pc_next(resp_pc_q);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = {pc_q[31:2], 2'b00};
    assign bus.ins_valid      = rst_n && !fifo_empty;
    assign bus.ins            = (rst_n && !fifo_empty) ? head.word : NOP_INSN;
    assign bus.ins_pc         = (rst_n && !fifo_empty) ? head.pc : 32'h0000_0000;
    assign bus.fetch_trap     = rst_n && trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (DEPTH=2, RESET_PC=0) with an
// in-order instruction memory model of configurable latency and a decode-side
// expected-PC queue.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          n_acc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE_0003;
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive the memory response for the current cycle, then let logic settle.
  task automatic settle();
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(pend_addr[0]);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
    #1;
  endtask

  // Record this cycle's handshakes, then move to just after the next edge.
  task automatic advance();
    logic [31:0] e;
    if (bus.ins_valid && bus.ins_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_bad++;
        $display("FAIL extra_ins: got pc=%h, none expected (cycle %0d)", bus.ins_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        check32("ins_pc", bus.ins_pc, e);
        check32("ins_word", bus.ins, mem_word(e));
      end
    end
    if (bus.imem_resp_valid) begin
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend_addr.push_back(bus.imem_req_addr);
      pend_due.push_back(cyc + lat);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.ins_ready       = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    lat   = 1;
    n_acc = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    check32("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check32("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    check32("rst_ins", bus.ins, 32'h0000_0013);
    check32("rst_ins_pc", bus.ins_pc, 32'h0);
    check32("rst_trap", 32'(bus.fetch_trap), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // T1: streaming after reset, 1-cycle memory, decode always ready.
    do_reset();
    bus.ins_ready = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
    for (int k = 0; k < 8; k++) begin
      settle();
      check32("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check32("t1_req_addr", bus.imem_req_addr, 32'(4 * k));
      check32("t1_ins_valid", 32'(bus.ins_valid), (k >= 2) ? 32'd1 : 32'd0);
      advance();
    end
    check32("t1_drain", 32'(exp_q.size()), 32'd0);

    // T2: decode stalled for a while -> two words held, head stable at 0x0.
    do_reset();
    bus.ins_ready = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int k = 0; k < 6; k++) begin
      settle();
      check32("t2_req_valid", 32'(bus.imem_req_valid), (k < 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check32("t2_hold_valid", 32'(bus.ins_valid), 32'd1);
        check32("t2_hold_pc", bus.ins_pc, 32'h0);
        check32("t2_hold_ins", bus.ins, mem_word(32'h0));
      end
      advance();
    end
    check32("t2_req_count", 32'(n_acc), 32'd2);
    bus.ins_ready = 1'b1;
    for (int k = 6; k < 9; k++) begin
      settle();
      if (k == 6) begin
        check32("t2_resume_valid", 32'(bus.imem_req_valid), 32'd1);
        check32("t2_resume_addr", bus.imem_req_addr, 32'h8);
      end
      advance();
    end
    check32("t2_drain", 32'(exp_q.size()), 32'd0);

    // T3: two requests in flight (3-cycle memory), redirect to 0x100.
    do_reset();
    lat = 3;
    bus.ins_ready = 1'b1;
    settle(); check32("t3_addr0", bus.imem_req_addr, 32'h0); advance();
    settle(); check32("t3_addr1", bus.imem_req_addr, 32'h4); advance();
    redirect_to(32'h0000_0100);
    settle();
    check32("t3_full_at_redirect", 32'(bus.imem_req_valid), 32'd0);
    advance();
    bus.redirect_valid = 1'b0;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    for (int k = 3; k < 10; k++) begin
      settle();
      case (k)
        3: check32("t3_c3_req_valid", 32'(bus.imem_req_valid), 32'd0);
        4: begin
          check32("t3_c4_req_valid", 32'(bus.imem_req_valid), 32'd1);
          check32("t3_c4_req_addr", bus.imem_req_addr, 32'h100);
        end
        5: check32("t3_c5_req_addr", bus.imem_req_addr, 32'h104);
        6: check32("t3_c6_req_valid", 32'(bus.imem_req_valid), 32'd0);
        8: check32("t3_c8_ins_valid", 32'(bus.ins_valid), 32'd1);
        default: ;
      endcase
      if (k < 8) check32("t3_no_stale", 32'(bus.ins_valid), 32'd0);
      advance();
    end
    check32("t3_drain", 32'(exp_q.size()), 32'd0);

    // T4: redirect in the same cycle as a response and an ins pop.
    do_reset();
    bus.ins_ready = 1'b1;
    exp_q.push_back(32'h0);
    settle(); advance();
    settle(); advance();
    redirect_to(32'h0000_0100);
    settle();
    check32("t4_pop_at_redirect", 32'(bus.ins_valid), 32'd1);
    check32("t4_resp_at_redirect", 32'(bus.imem_resp_valid), 32'd1);
    check32("t4_req_at_redirect", 32'(bus.imem_req_valid), 32'd0);
    advance();
    bus.redirect_valid = 1'b0;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    settle();
    check32("t4_r1_empty", 32'(bus.ins_valid), 32'd0);
    check32("t4_r1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check32("t4_r1_req_addr", bus.imem_req_addr, 32'h100);
    advance();
    settle(); check32("t4_r2_empty", 32'(bus.ins_valid), 32'd0); advance();
    settle(); check32("t4_r3_valid", 32'(bus.ins_valid), 32'd1); advance();
    settle(); advance();
    check32("t4_drain", 32'(exp_q.size()), 32'd0);

    // T5: PC wrap 0xFFFF_FFF8 -> 0xFFFF_FFFC -> 0x0000_0000.
    do_reset();
    bus.ins_ready = 1'b1;
    redirect_to(32'hFFFF_FFF8);
    settle();
    check32("t5_req_at_redirect", 32'(bus.imem_req_valid), 32'd0);
    advance();
    bus.redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    settle(); check32("t5_addr_f8", bus.imem_req_addr, 32'hFFFF_FFF8); advance();
    settle(); check32("t5_addr_fc", bus.imem_req_addr, 32'hFFFF_FFFC); advance();
    settle(); check32("t5_addr_00", bus.imem_req_addr, 32'h0000_0000); advance();
    settle(); advance();
    settle(); advance();
    check32("t5_drain", 32'(exp_q.size()), 32'd0);

    // T6: redirect to a misaligned target.
    do_reset();
    bus.ins_ready = 1'b1;
    redirect_to(32'h0000_0102);
    settle();
    advance();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 1; k < 3; k++) begin
      settle();
      check32("t6_trap_set", 32'(bus.fetch_trap), 32'd1);
      check32("t6_trap_no_req", 32'(bus.imem_req_valid), 32'd0);
      advance();
    end
    redirect_to(32'h0000_0200);
    settle();
    check32("t6_trap_held", 32'(bus.fetch_trap), 32'd1);
    advance();
    bus.redirect_valid = 1'b0;
    exp_q.push_back(32'h200);
    settle();
    check32("t6_trap_clear", 32'(bus.fetch_trap), 32'd0);
    check32("t6_resume_valid", 32'(bus.imem_req_valid), 32'd1);
    check32("t6_resume_addr", bus.imem_req_addr, 32'h200);
    advance();
    settle(); advance();
    settle(); advance();
`else
    exp_q.push_back(32'h100);
    settle();
    check32("t6_no_trap", 32'(bus.fetch_trap), 32'd0);
    check32("t6_aligned_valid", 32'(bus.imem_req_valid), 32'd1);
    check32("t6_aligned_addr", bus.imem_req_addr, 32'h100);
    advance();
    settle(); advance();
    settle(); advance();
`endif
    check32("t6_drain", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
